// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte push side and async_transmitter handshake for uart_tx_fifo.
// master = upstream producer plus transmitter, slave = the FIFO block itself.
interface uart_tx_fifo_if #(
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic [7:0]            wr_data;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   count;
   logic                  TxD_start;
   logic [7:0]            TxD_data;
   logic                  TxD_busy;

   modport master (
      output wr_en, wr_data, TxD_busy,
      input  full, empty, count, TxD_start, TxD_data
   );

   modport slave (
      input  wr_en, wr_data, TxD_busy,
      output full, empty, count, TxD_start, TxD_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds async_transmitter one byte at a time.
// Bytes pushed while the transmitter is mid-frame are queued and issued in
// order with a one-cycle TxD_start pulse each.
// Optional feature: define UART_TX_FIFO_DROPCNT_EN to add the drop_count port,
// a saturating count of pushes discarded because the FIFO was full.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned BUSY_WAIT  = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus
`ifdef UART_TX_FIFO_DROPCNT_EN
   ,
   output logic [7:0]     drop_count
`endif
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned TW    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_RISE = 2'd1;
   localparam logic [1:0] ST_WAIT_FALL = 2'd2;

   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
   localparam logic [TW-1:0]         WAIT_ONE = 1;
   localparam logic [TW-1:0]         WAIT_END = TW'(BUSY_WAIT - 1);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH_LOG2:0]   count_next;
   logic                  full_q;
   logic                  empty_q;
   logic [1:0]            state;
   logic [TW-1:0]         wait_cnt;
   logic                  start_q;
   logic [7:0]            data_q;
   logic                  push;
   logic                  pop;

   // Accept only on registered flags, so a push while full is dropped even
   // when a pop happens on the same edge.
   assign push = bus.wr_en && !full_q;
   assign pop  = (state == ST_IDLE) && !empty_q && !bus.TxD_busy;

   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = count_q;
   assign bus.TxD_start = start_q;
   assign bus.TxD_data  = data_q;

   // Next occupancy from this cycle's push/pop decision.
   always_comb begin
      count_next = count_q;
      case ({push, pop})
         2'b10:   count_next = count_q + CNT_ONE;
         2'b01:   count_next = count_q - CNT_ONE;
         default: count_next = count_q;
      endcase
   end

   // Storage write; the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count_q <= count_next;
         full_q  <= (count_next == CNT_FULL);
         empty_q <= (count_next == '0);
      end
   end

   // Transmit handshake: pulse start with the head byte, wait for busy to
   // rise (bounded by BUSY_WAIT), then wait for it to fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         start_q  <= 1'b0;
         data_q   <= 8'h00;
      end else begin
         start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (pop) begin
                  data_q  <= mem[rd_ptr];
                  start_q <= 1'b1;
                  state   <= ST_WAIT_RISE;
               end
            end
            ST_WAIT_RISE: begin
               if (bus.TxD_busy) begin
                  state <= ST_WAIT_FALL;
               end else if (wait_cnt == WAIT_END) begin
                  state <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_ONE;
               end
            end
            ST_WAIT_FALL: begin
               if (!bus.TxD_busy) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef UART_TX_FIFO_DROPCNT_EN
   // Saturating count of pushes rejected because the FIFO was full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= 8'h00;
      end else if (bus.wr_en && full_q && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a behavioural
// transmitter busy model.
module tb_uart_tx_fifo;

   localparam int unsigned DL = 4;
   localparam int unsigned BW = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

`ifdef UART_TX_FIFO_DROPCNT_EN
   logic [7:0] drop_count;
`endif

   uart_tx_fifo #(
      .DEPTH_LOG2(DL),
      .BUSY_WAIT (BW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef UART_TX_FIFO_DROPCNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q [$];

   // Transmitter model: busy rises half a cycle after a seen start pulse and
   // stays high for frame_len cycles; hold forces busy, mute suppresses it.
   int busy_cnt  = 0;
   int frame_len = 10;
   bit hold      = 1'b0;
   bit mute      = 1'b0;
   assign bus.TxD_busy = hold || (busy_cnt != 0);

   int cyc = 0;
   always @(posedge clk) cyc++;

   int pulses     = 0;
   int last_pulse = -100;
   int gap        = 0;
   bit prev_start = 1'b0;
   int count_max  = 0;

   // Output monitor: compare each issued byte against the scoreboard head.
   always @(negedge clk) begin
      if (bus.TxD_start === 1'b1) begin
         pulses++;
         gap        = cyc - last_pulse;
         last_pulse = cyc;
         if (prev_start) check("start_back_to_back", 32'd1, 32'd0);
         if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
         else check("tx_data", {24'd0, bus.TxD_data}, {24'd0, exp_q.pop_front()});
         if (!mute) busy_cnt = frame_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      prev_start = (bus.TxD_start === 1'b1);
      if (int'(bus.count) > count_max) count_max = int'(bus.count);
   end

   // Drive one push for one edge; caller is just after a negedge.
   task automatic push(input logic [7:0] d, input bit accept);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      if (accept) exp_q.push_back(d);
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // Wait until everything expected has been issued and the handshake is quiet.
   task automatic wait_idle(input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.TxD_busy && bus.empty && !bus.TxD_start) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (BW + 3) @(negedge clk);
      check("drain_in_time", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   int p0;

   initial begin
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_count", {27'd0, bus.count}, 32'd0);
      check("rst_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_full",  {31'd0, bus.full}, 32'd0);
      check("rst_start", {31'd0, bus.TxD_start}, 32'd0);
      check("rst_data",  {24'd0, bus.TxD_data}, 32'h00);
`ifdef UART_TX_FIFO_DROPCNT_EN
      check("rst_drop", {24'd0, drop_count}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // single byte latency
      push(8'h41, 1'b1);
      check("t1_count_after_push", {27'd0, bus.count}, 32'd1);
      check("t1_empty_after_push", {31'd0, bus.empty}, 32'd0);
      check("t1_start_early", {31'd0, bus.TxD_start}, 32'd0);
      @(negedge clk);
      check("t1_start", {31'd0, bus.TxD_start}, 32'd1);
      check("t1_data", {24'd0, bus.TxD_data}, 32'h41);
      check("t1_count_after_pop", {27'd0, bus.count}, 32'd0);
      wait_idle(60);

      // fill to full while the transmitter is held busy
      hold = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
      check("t2_full", {31'd0, bus.full}, 32'd1);
      check("t2_count", {27'd0, bus.count}, 32'd16);
      check("t2_empty", {31'd0, bus.empty}, 32'd0);

      // push while full on the same edge as the first pop: dropped
      p0          = pulses;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hAA;
      hold        = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("t3_count", {27'd0, bus.count}, 32'd15);
      check("t3_full", {31'd0, bus.full}, 32'd0);
`ifdef UART_TX_FIFO_DROPCNT_EN
      check("t3_drop_one", {24'd0, drop_count}, 32'd1);
`endif
      wait_idle(400);
      check("t2_pulse_count", pulses - p0, 32'd16);
      check("t2_empty_end", {31'd0, bus.empty}, 32'd1);

`ifdef UART_TX_FIFO_DROPCNT_EN
      hold = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
      for (int i = 0; i < 300; i++) push(8'hEE, 1'b0);
      check("t3_drop_sat", {24'd0, drop_count}, 32'hFF);
      check("t3_count_full", {27'd0, bus.count}, 32'd16);
      hold = 1'b0;
      wait_idle(400);
`endif

      // pointer wrap with bursts of four
      count_max = 0;
      p0        = pulses;
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < 4; k++) push(8'(8'h50 + b * 4 + k), 1'b1);
         wait_idle(100);
      end
      check("t4_count_max", count_max, 32'd3);
      check("t4_pulses", pulses - p0, 32'd40);

      // busy never rises: bounded wait, then next byte
      mute = 1'b1;
      p0   = pulses;
      push(8'h61, 1'b1);
      push(8'h62, 1'b1);
      wait_idle(60);
      check("t5_pulses", pulses - p0, 32'd2);
      check("t5_gap", gap, 32'd5);
      mute = 1'b0;

      // async reset while waiting for busy to fall with bytes queued
      push(8'h70, 1'b1);
      for (int i = 0; i < 5; i++) push(8'(8'h71 + i), 1'b0);
      check("t6_busy_before", {31'd0, bus.TxD_busy}, 32'd1);
      check("t6_count_before", {27'd0, bus.count}, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_count", {27'd0, bus.count}, 32'd0);
      check("t6_rst_empty", {31'd0, bus.empty}, 32'd1);
      check("t6_rst_start", {31'd0, bus.TxD_start}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      p0  = pulses;
      repeat (25) @(negedge clk);
      check("t6_no_pulses", pulses - p0, 32'd0);
      check("t6_busy_fell", {31'd0, bus.TxD_busy}, 32'd0);
      check("t6_scoreboard_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
